matrix_ls_sequencer: RTL and testbench

- Sequences one matrix load/store instruction into per-row scratchpad requests.
- Sits between the issue queue and the scratchpad port. Accepts one instruction per `ready` handshake.
- Issues ROWS row requests at `rs + sext(imm) + i*stride`, holding each request until `mhit`.
- Pulses `done` with the destination register once the last row is accepted.

---
 rtl/matrix_ls_sequencer.sv | 147 ++++++++++++++
 tb/tb_matrix_ls_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ls_sequencer.sv
// Matrix load/store sequencer: expands one instruction into ROWS scratchpad row requests.
// Optional watchdog on stalled requests is enabled by defining MATLS_TIMEOUT_EN.
module matrix_ls_sequencer #(
    parameter int ROWS    = 4,
    parameter int ROW_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enable,
    input  logic [1:0]       ls_in,
    input  logic [4:0]       rd_in,
    input  logic [31:0]      rs_in,
    input  logic [31:0]      stride_in,
    input  logic [10:0]      imm_in,
    input  logic             mhit,
    output logic             ready,
    output logic             sp_req,
    output logic             sp_ren,
    output logic             sp_wen,
    output logic [31:0]      sp_addr,
    output logic [ROW_W-1:0] sp_row,
    output logic [4:0]       sp_rd,
    output logic             done,
    output logic [4:0]       done_rd,
`ifdef MATLS_TIMEOUT_EN
    output logic [1:0]       done_ls,
    output logic             timeout
`else
    output logic [1:0]       done_ls
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t            state, state_next;
    logic [31:0]       addr;
    logic [31:0]       stride;
    logic [ROW_W-1:0]  row;
    logic [4:0]        rd;
    logic [1:0]        ls;
    logic              accept;
    logic              last_row;

    // Base address: rs plus the sign-extended 11-bit immediate, modulo 2^32.
    function automatic logic [31:0] base_addr(input logic [31:0] rs, input logic signed [10:0] imm);
        logic signed [31:0] imm_ext;
        imm_ext   = 32'(imm);
        base_addr = rs + imm_ext;
    endfunction

    assign accept   = enable && (ls_in == 2'b01 || ls_in == 2'b10);
    assign last_row = (row == LAST_ROW);

`ifdef MATLS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             expire;

    assign expire = (state == ISSUE) && !mhit && (stall_cnt == CNT_LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= expire;
            if ((state == IDLE && accept) || mhit)
                stall_cnt <= '0;
            else if (state == ISSUE)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            addr   <= '0;
            stride <= '0;
            row    <= '0;
            rd     <= '0;
            ls     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                addr   <= base_addr(rs_in, imm_in);
                stride <= stride_in;
                rd     <= rd_in;
                ls     <= ls_in;
                row    <= '0;
            end else if (state == ISSUE && mhit && !last_row) begin
                addr <= addr + stride;
                row  <= row + ROW_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = ISSUE;
            ISSUE: begin
                if (mhit && last_row)
                    state_next = DONE;
`ifdef MATLS_TIMEOUT_EN
                else if (expire)
                    state_next = IDLE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from state and latched fields only; nothing passes through from enable/mhit.
    always_comb begin
        ready   = (state == IDLE);
        sp_req  = 1'b0;
        sp_ren  = 1'b0;
        sp_wen  = 1'b0;
        sp_addr = '0;
        sp_row  = '0;
        sp_rd   = '0;
        done    = 1'b0;
        done_rd = '0;
        done_ls = '0;
        if (state == ISSUE) begin
            sp_req  = 1'b1;
            sp_ren  = (ls == 2'b01);
            sp_wen  = (ls == 2'b10);
            sp_addr = addr;
            sp_row  = row;
            sp_rd   = rd;
        end
        if (state == DONE) begin
            done    = 1'b1;
            done_rd = rd;
            done_ls = ls;
        end
    end

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Directed bench for matrix_ls_sequencer: load, store with stall, wrap, ignored enables,
// mid-operation reset and, when MATLS_TIMEOUT_EN is defined, the stall watchdog.
module tb_matrix_ls_sequencer;

    logic        CLK;
    logic        nRST;
    logic        enable;
    logic [1:0]  ls_in;
    logic [4:0]  rd_in;
    logic [31:0] rs_in;
    logic [31:0] stride_in;
    logic [10:0] imm_in;
    logic        mhit;
    logic        ready;
    logic        sp_req;
    logic        sp_ren;
    logic        sp_wen;
    logic [31:0] sp_addr;
    logic [1:0]  sp_row;
    logic [4:0]  sp_rd;
    logic        done;
    logic [4:0]  done_rd;
    logic [1:0]  done_ls;
`ifdef MATLS_TIMEOUT_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

`ifdef MATLS_TIMEOUT_EN
    matrix_ls_sequencer #(.ROWS(4), .ROW_W(2), .TIMEOUT(8)) dut (
`else
    matrix_ls_sequencer #(.ROWS(4), .ROW_W(2), .TIMEOUT(64)) dut (
`endif
        .CLK(CLK), .nRST(nRST), .enable(enable), .ls_in(ls_in), .rd_in(rd_in),
        .rs_in(rs_in), .stride_in(stride_in), .imm_in(imm_in), .mhit(mhit),
        .ready(ready), .sp_req(sp_req), .sp_ren(sp_ren), .sp_wen(sp_wen),
        .sp_addr(sp_addr), .sp_row(sp_row), .sp_rd(sp_rd), .done(done),
        .done_rd(done_rd),
`ifdef MATLS_TIMEOUT_EN
        .done_ls(done_ls), .timeout(timeout)
`else
        .done_ls(done_ls)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples happen 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] ls, input logic [4:0] rd, input logic [31:0] rs,
                         input logic [10:0] imm, input logic [31:0] stride);
        enable = 1'b1; ls_in = ls; rd_in = rd; rs_in = rs; imm_in = imm; stride_in = stride;
        step();
        enable = 1'b0; ls_in = 2'b00;
    endtask

    initial begin
        int dones;
        nRST = 1'b0; enable = 1'b0; ls_in = '0; rd_in = '0; rs_in = '0;
        stride_in = '0; imm_in = '0; mhit = 1'b0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_req", sp_req, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", sp_addr, 0);
        @(negedge CLK); nRST = 1'b1;
        step();

        // Load, mhit every cycle
        mhit = 1'b1;
        issue(2'b01, 5'd5, 32'h1000, 11'h010, 32'h40);
        for (int i = 0; i < 4; i++) begin
            chk("ld_req", sp_req, 1);
            chk("ld_ren", sp_ren, 1);
            chk("ld_wen", sp_wen, 0);
            chk("ld_addr", sp_addr, 32'h1010 + 32'h40 * i);
            chk("ld_row", sp_row, i);
            chk("ld_rd", sp_rd, 5);
            chk("ld_ready", ready, 0);
            step();
        end
        chk("ld_done", done, 1);
        chk("ld_done_rd", done_rd, 5);
        chk("ld_done_ls", done_ls, 1);
        chk("ld_done_req", sp_req, 0);
        step();
        chk("ld_ready_back", ready, 1);
        chk("ld_done_clr", done, 0);
        chk("ld_done_rd_clr", done_rd, 0);

        // Store with negative immediate and a 3-cycle stall on row 1
        issue(2'b10, 5'd9, 32'h100, 11'h7F0, 32'h20);
        chk("st_addr0", sp_addr, 32'h0F0);
        chk("st_wen", sp_wen, 1);
        chk("st_ren", sp_ren, 0);
        step();
        mhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_stall_addr", sp_addr, 32'h110);
            chk("st_stall_row", sp_row, 1);
            chk("st_stall_req", sp_req, 1);
            step();
        end
        mhit = 1'b1;
        chk("st_hold_addr", sp_addr, 32'h110);
        step();
        chk("st_adv_addr", sp_addr, 32'h130);
        chk("st_adv_row", sp_row, 2);
        step();
        chk("st_addr3", sp_addr, 32'h150);
        step();
        chk("st_done", done, 1);
        chk("st_done_rd", done_rd, 9);
        chk("st_done_ls", done_ls, 2);
        step();

        // Address wrap, with a stray enable during ISSUE
        issue(2'b01, 5'd2, 32'hFFFF_FFF0, 11'h000, 32'h10);
        chk("wr_addr0", sp_addr, 32'hFFFF_FFF0);
        step();
        chk("wr_addr1", sp_addr, 32'h0000_0000);
        enable = 1'b1; ls_in = 2'b10; rd_in = 5'd7;
        step();
        enable = 1'b0; ls_in = 2'b00;
        chk("wr_addr2", sp_addr, 32'h0000_0010);
        chk("wr_rd_kept", sp_rd, 2);
        step();
        chk("wr_addr3", sp_addr, 32'h0000_0020);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dones++;
        end
        chk("wr_one_done", dones, 1);
        chk("wr_idle", ready, 1);

        // Non-operation codes dropped in IDLE
        enable = 1'b1; ls_in = 2'b00;
        step();
        chk("nop00_req", sp_req, 0);
        chk("nop00_ready", ready, 1);
        ls_in = 2'b11;
        step();
        chk("nop11_req", sp_req, 0);
        chk("nop11_ready", ready, 1);
        enable = 1'b0; ls_in = 2'b00;

        // Asynchronous reset during row 2
        issue(2'b01, 5'd3, 32'h2000, 11'h000, 32'h4);
        step();
        step();
        chk("rs_row2", sp_row, 2);
        #2 nRST = 1'b0;
        #1;
        chk("rs_async_ready", ready, 1);
        chk("rs_async_req", sp_req, 0);
        chk("rs_async_addr", sp_addr, 0);
        chk("rs_async_row", sp_row, 0);
        chk("rs_async_rd", sp_rd, 0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) dones++;
        end
        chk("rs_no_done", dones, 0);
        nRST = 1'b1;
        step();
        issue(2'b01, 5'd4, 32'h3000, 11'h004, 32'h8);
        chk("rs_new_row0", sp_row, 0);
        chk("rs_new_addr0", sp_addr, 32'h3004);
        step();
        chk("rs_new_addr1", sp_addr, 32'h300C);
        dones = 0;
        for (int i = 0; i < 10 && !ready; i++) begin
            if (done) dones++;
            step();
        end
        chk("rs_new_ready", ready, 1);
        chk("rs_new_done", dones, 1);

`ifdef MATLS_TIMEOUT_EN
        // Watchdog: no mhit for 8 ISSUE cycles aborts
        mhit = 1'b0;
        issue(2'b01, 5'd6, 32'h4000, 11'h000, 32'h10);
        for (int i = 0; i < 8; i++) begin
            chk("to_req", sp_req, 1);
            chk("to_quiet", timeout, 0);
            step();
        end
        chk("to_pulse", timeout, 1);
        chk("to_ready", ready, 1);
        chk("to_no_done", done, 0);
        step();
        chk("to_pulse_end", timeout, 0);

        // mhit on the 8th cycle wins over the limit
        issue(2'b01, 5'd6, 32'h4000, 11'h000, 32'h10);
        for (int i = 0; i < 7; i++) step();
        mhit = 1'b1;
        step();
        chk("to_win_row", sp_row, 1);
        chk("to_win_req", sp_req, 1);
        chk("to_win_quiet", timeout, 0);
        step(); step(); step();
        chk("to_win_done", done, 1);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
